shift_seq_ctrl: RTL

- Multi-cycle sequencing controller for the 16-bit logarithmic shifter datapath.
- Accepts one shift command per transaction over a valid/ready handshake.
- Drives the word through log2(WIDTH) conditional stages (1, 2, 4, 8), one stage per clock.
- Returns the result over a second valid/ready handshake. Sits between the command source and the consumer; replaces a fully combinational 4-stage chain where timing requires it.

---
 rtl/shift_pkg.sv | 26 ++
 rtl/MUX_2x1.sv | 15 +
 rtl/shift_stage_lr.sv | 60 ++++++
 rtl/shift_seq_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle logarithmic shifter controller.
//   clog2_f     : derives the stage count (and amount width) from the word width
//   state_e     : controller states
//   DIR_LEFT/DIR_RIGHT : encoding of the dir input
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Ceiling log2, evaluated at elaboration time only.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/MUX_2x1.sv
// Two-input single-bit multiplexer cell.
//   a_i   : selected when sel_i = 0
//   b_i   : selected when sel_i = 1
//   sel_i : select
//   y_o   : output
module MUX_2x1 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/shift_stage_lr.sv
// One combinational shift stage whose distance is 2^idx_i, built from MUX_2x1
// cells. Every fixed distance is wired up in parallel, the direction chooses
// left/right per bit, the stage index picks one distance, and the enable
// chooses between the shifted word and the unmodified input.
//   data_i : word entering the stage
//   idx_i  : stage index k, shift distance 2^k
//   dir_i  : 0 = left, 1 = right
//   fill_i : bit shifted into vacated MSBs on right shifts
//   en_i   : 1 = apply the shift, 0 = pass data_i through
//   data_o : word leaving the stage
module shift_stage_lr #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int IDX_W  = 2
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             dir_i,
  input  logic             fill_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  for (genvar d = 0; d < STAGES; d++) begin : g_dist
    localparam int DIST = 1 << d;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] pick;
    logic             hit;

    assign hit = (idx_i == IDX_W'(d));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic lft;
      logic rgt;
      if (i >= DIST) begin : g_l
        assign lft = data_i[i-DIST];
      end else begin : g_lz
        assign lft = 1'b0;
      end
      if (i + DIST < WIDTH) begin : g_r
        assign rgt = data_i[i+DIST];
      end else begin : g_rf
        assign rgt = fill_i;
      end
      MUX_2x1 u_dir (.a_i(lft), .b_i(rgt), .sel_i(dir_i), .y_o(cand[i]));

      // Distance select: a priority chain where the highest matching index wins.
      if (d == 0) begin : g_first
        assign pick[i] = cand[i];
      end else begin : g_next
        MUX_2x1 u_sel (.a_i(g_dist[d-1].pick[i]), .b_i(cand[i]), .sel_i(hit), .y_o(pick[i]));
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_en
    MUX_2x1 u_en (.a_i(data_i[i]), .b_i(g_dist[STAGES-1].pick[i]), .sel_i(en_i), .y_o(data_o[i]));
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sequencing controller for the logarithmic shifter. A command is
// taken over the in_valid/in_ready handshake, the word is walked through
// STAGES conditional stages (distances 1, 2, 4, ...) one per clock using a
// single reused shift_stage_lr, and the result is held on q until the
// out_valid/out_ready handshake completes.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : command handshake
//   data, amt, dir, arith : operand, shift amount, direction, arithmetic-fill flag
//   out_valid, out_ready : result handshake
//   q                   : registered result (working register)
//   busy                : high whenever the controller is not IDLE
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            data,
  input  logic [clog2_f(WIDTH)-1:0]   amt,
  input  logic                        dir,
  input  logic                        arith,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            q,
  output logic                        busy
);

  localparam int STAGES = clog2_f(WIDTH);
  localparam int IDX_W  = (STAGES > 1) ? clog2_f(STAGES) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic [STAGES-1:0]   amt_q;
  logic                dir_q;
  logic                arith_q;
  logic                accept;
  logic                fill;
  logic [WIDTH-1:0]    stage_out;

  assign accept = (state_q == IDLE) && in_valid;

  // During an arithmetic right shift the MSB never changes, so the working
  // register's MSB is the latched operand sign.
  assign fill = arith_q && (dir_q == DIR_RIGHT) && work_q[WIDTH-1];

  shift_stage_lr #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .IDX_W  (IDX_W)
  ) u_stage (
    .data_i (work_q),
    .idx_i  (cnt_q),
    .dir_i  (dir_q),
    .fill_i (fill),
    .en_i   (amt_q[cnt_q]),
    .data_o (stage_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = stage_out;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(STAGES - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Command attributes only matter once a command is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      amt_q   <= amt;
      dir_q   <= dir;
      arith_q <= arith;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign q         = work_q;

endmodule
